// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, predecode of the fetched word and a
// table of 2-bit saturating counters that predicts conditional branches.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] inst_mem_addr,
    input  logic [31:0] inst_mem_read_data,
    output logic [31:0] IF_pc,
    output logic        IF_take,
    input  logic        EX_MEM_stall,
    input  logic        EX_flush,
    input  logic [31:0] EX_redirect_pc,
    input  logic        EX_update_valid,
    input  logic [31:0] EX_update_pc,
    input  logic        EX_update_taken
);
    localparam int         BHT_SIZE  = 1 << BHT_IDX_W;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        if (up) begin
            if (c == 2'b11) r = 2'b11;
            else            r = c + 2'b01;
        end else begin
            if (c == 2'b00) r = 2'b00;
            else            r = c - 2'b01;
        end
        return r;
    endfunction

    logic [31:0]          pc_r;
    logic [1:0]           bht_r [BHT_SIZE];
    logic [BHT_IDX_W-1:0] lookup_idx_s;
    logic [BHT_IDX_W-1:0] update_idx_s;
    logic [1:0]           lookup_ctr_s;
    logic                 pred_taken_s;
    logic [31:0]          imm_s;
    logic [31:0]          target_s;
    logic [31:0]          seq_pc_s;
    logic [31:0]          next_pc_s;

    assign lookup_idx_s  = pc_r[BHT_IDX_W+1:2];
    assign update_idx_s  = EX_update_pc[BHT_IDX_W+1:2];
    assign lookup_ctr_s  = bht_r[lookup_idx_s];
    assign target_s      = pc_r + imm_s;
    assign seq_pc_s      = pc_r + 32'd4;
    assign inst_mem_addr = pc_r;
    assign IF_pc         = pc_r;
    assign IF_take       = pred_taken_s & ~EX_flush;

    // Predecode the fetched word into a prediction and its immediate.
    always_comb begin
        pred_taken_s = 1'b0;
        imm_s        = 32'h0000_0000;
        case (inst_mem_read_data[6:0])
            OP_BRANCH: begin
                pred_taken_s = lookup_ctr_s[1];
                imm_s        = imm_b(inst_mem_read_data);
            end
            OP_JAL: begin
                pred_taken_s = 1'b1;
                imm_s        = imm_j(inst_mem_read_data);
            end
            default: begin
                pred_taken_s = 1'b0;
                imm_s        = 32'h0000_0000;
            end
        endcase
    end

    // Next-PC selection; a redirect from EX wins over a stall.
    always_comb begin
        next_pc_s = seq_pc_s;
        if (EX_flush)          next_pc_s = EX_redirect_pc;
        else if (EX_MEM_stall) next_pc_s = pc_r;
        else if (IF_take)      next_pc_s = target_s;
        else                   next_pc_s = seq_pc_s;
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (!reset) pc_r <= RESET_PC;
        else        pc_r <= next_pc_s;
    end

    // Counter table: reset to weakly not-taken, trained from EX independent of stall/flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < BHT_SIZE; k++) bht_r[k] <= 2'b01;
        end else if (EX_update_valid) begin
            bht_r[update_idx_s] <= sat_step(bht_r[update_idx_s], EX_update_taken);
        end else begin
            bht_r[update_idx_s] <= bht_r[update_idx_s];
        end
    end
endmodule

// File: doc/if_fetch_unit.md
# IF_fetch_unit

Instruction-fetch stage on the producer side of the IF/ID pipeline register. Holds the program counter, drives the instruction-memory address, predecodes the returned word, and predicts taken/not-taken with a table of 2-bit saturating counters. Its prediction (`IF_take`) and fetched word feed the IF/ID register. EX-stage redirects and training updates close the loop.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded during reset.
- `BHT_IDX_W`, default 6: index width of the counter table (2^BHT_IDX_W entries).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-low. It is sampled only at the rising edge of `clk`.
- `inst_mem_addr` out 32: fetch address. Always equals the current PC (combinational).
- `inst_mem_read_data` in 32: instruction word at `inst_mem_addr`, returned in the same cycle.
- `IF_pc` out 32: current PC, passed alongside the fetched word.
- `IF_take` out 1: 1 when the current word is predicted taken.
- `EX_MEM_stall` in 1: hold the PC this cycle.
- `EX_flush` in 1: mispredict or redirect from EX.
- `EX_redirect_pc` in 32: corrected PC. Valid while `EX_flush` is 1.
- `EX_update_valid` in 1: train the counter table this cycle.
- `EX_update_pc` in 32: PC of the resolved conditional branch.
- `EX_update_taken` in 1: actual outcome of that branch.

## Operation
- **Table index**: `pc[BHT_IDX_W+1:2]` selects a counter, for both lookup and update.
- **Predecode** of `inst_mem_read_data` (`i`). The opcode is `i[6:0]`.
  - 7'b1100011 (conditional branch): predicted taken iff `counter[1]==1`.
    - Immediate = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}.
  - 7'b1101111 (JAL): always predicted taken.
    - Immediate = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}.
  - Any other opcode, including 32'h0 bubbles: not taken.
- **Target** = PC + sign-extended immediate, modulo 2^32 (wrap, no trap). The sequential address is PC + 4, also modulo 2^32.
- **`IF_take`** = predicted taken AND `EX_flush`==0.
- **Next PC**, in priority order:
  1. `reset`==0: `RESET_PC`.
  2. `EX_flush`: `EX_redirect_pc`. This overrides a stall.
  3. `EX_MEM_stall`: hold the current PC.
  4. `IF_take`: target.
  5. Otherwise: PC + 4.
- **Counter update** when `EX_update_valid`==1:
  - taken: increment, saturating at 2'b11.
  - not taken: decrement, saturating at 2'b00.
  - Updates happen regardless of stall or flush.
  - Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- **Aliasing**: PCs that share index bits share a counter. No tags are stored.

## Timing
- Reset (`reset`==0 at a rising edge):
  - PC <= `RESET_PC`, so `inst_mem_addr` and `IF_pc` equal `RESET_PC` in the following cycle.
  - All counters <= 2'b01.
  - Training inputs are ignored during reset.
  - Reset mid-operation discards any pending redirect.
- `IF_take` is combinational from the PC register, `inst_mem_read_data`, the table, and `EX_flush`. There are no registered outputs other than the PC.
- Taken prediction in cycle n: PC = target in cycle n+1. No bubble is inserted.
- Flush in cycle n: PC = `EX_redirect_pc` in cycle n+1. `IF_take` is 0 in cycle n.
- Stall: PC and `inst_mem_addr` are stable for every stalled cycle. `IF_take` keeps reflecting the held word.
- Update write takes effect at the edge. A lookup of the same index in that same cycle sees the old value; the new value is visible from cycle n+1.
- Simultaneous flush, stall and update: the PC is redirected and the counter is still trained.

## Test plan
- **Reset / sequential fetch**: hold `reset`=0 for 2 cycles, then release with NOP words (32'h00000013). Required: PC sequence 0, 4, 8, C; `IF_take`=0 throughout; every counter reads 01.
- **JAL prediction**: at PC 0x10, drive JAL with offset +0x20 (32'h0200006F). Required: `IF_take`=1; next PC is 0x30.
- **Branch training**: the BEQ at PC 0x40 has offset −8 and the counter starts at 01.
  - First fetch: predicted not taken, next PC 0x44.
  - After one `EX_update_taken`=1 update, the next fetch at 0x40 has `IF_take`=1 and next PC 0x38.
  - After three more taken updates the counter stays at 11.
  - After two not-taken updates it reads 01.
- **Flush beats stall**: `EX_MEM_stall`=1, `EX_flush`=1, `EX_redirect_pc`=0x100, with a taken JAL on the data bus. Required: `IF_take`=0; next PC is 0x100.
- **Stall hold**: stall for 3 cycles at PC 0x24. Required: `inst_mem_addr` = 0x24 for all 3 cycles, then 0x28 after release.
- **Wrap and mid-run reset**:
  - PC 0xFFFF_FFFC with a NOP: next PC is 0x0.
  - Asserting `reset`=0 while a flush is pending: PC = `RESET_PC` and all counters read 01 on the next cycle.
